// File: rtl/branch_squash_unit_if.sv
// Bubble/redirect bundle between the hazard unit, fetch and the IF/ID squash logic.
// pc_load is a one-cycle pulse with no back-pressure: PC must take pc_next on the cycle it is high.
interface branch_squash_unit_if;
  logic [1:0]  bubble;
  logic [31:0] br_target;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stall;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        seq_err;
  logic [15:0] squash_cnt;
  logic        drain_dbg;

  modport master (
    output bubble, br_target, if_pc, if_instr, stall,
    input  id_pc, id_instr, id_valid, pc_load, pc_next, seq_err, squash_cnt, drain_dbg
  );

  modport slave (
    input  bubble, br_target, if_pc, if_instr, stall,
    output id_pc, id_instr, id_valid, pc_load, pc_next, seq_err, squash_cnt, drain_dbg
  );
endinterface

// File: rtl/branch_squash_unit.sv
// IF/ID squash, PC redirect and bubble-sequence checking for the five-stage core.
// Optional squashed-slot counter enabled by defining SQUASH_STATS_EN.
module branch_squash_unit #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_squash_unit_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        redirect;
  logic        legal;
  logic [1:0]  prev_bubble_q;
  logic [31:0] id_pc_q, id_instr_q, pc_next_q;
  logic        id_valid_q, pc_load_q, seq_err_q;

  always_comb begin
    state_d  = state_q;
    redirect = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.bubble == 2'd3) begin
          state_d  = DRAIN;
          redirect = 1'b1;
        end
      end
      DRAIN: begin
        if (bus.bubble == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case ({prev_bubble_q, bus.bubble})
      {2'd0, 2'd0}, {2'd0, 2'd3}, {2'd3, 2'd2}, {2'd2, 2'd1}, {2'd1, 2'd0}: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prev_bubble_q <= 2'd0;
      pc_load_q     <= 1'b0;
      pc_next_q     <= 32'h0;
      seq_err_q     <= 1'b0;
      id_pc_q       <= 32'h0;
      id_instr_q    <= NOP_WORD;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_bubble_q <= bus.bubble;
      pc_load_q     <= redirect;
      if (redirect) pc_next_q <= bus.br_target;
      if (!legal) seq_err_q <= 1'b1;
      // Squash wins over a data-hazard stall; a stall only holds when no bubble is pending.
      if (bus.bubble != 2'd0) begin
        id_instr_q <= NOP_WORD;
        id_pc_q    <= bus.if_pc;
        id_valid_q <= 1'b0;
      end else if (!bus.stall) begin
        id_instr_q <= bus.if_instr;
        id_pc_q    <= bus.if_pc;
        id_valid_q <= 1'b1;
      end
    end
  end

`ifdef SQUASH_STATS_EN
  logic [15:0] squash_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      squash_cnt_q <= 16'h0000;
    end else if (bus.bubble != 2'd0 && squash_cnt_q != 16'hFFFF) begin
      squash_cnt_q <= squash_cnt_q + 16'd1;
    end
  end

  assign bus.squash_cnt = squash_cnt_q;
`else
  assign bus.squash_cnt = 16'h0000;
`endif

  assign bus.id_pc     = id_pc_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.pc_load   = pc_load_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.drain_dbg = (state_q == DRAIN);

endmodule

// File: doc/branch_squash_unit.md
# branch_squash_unit

Consumer side of the control-hazard bubble interface. Sits on the IF/ID pipeline register of the five-stage MIPS core. Samples the 2-bit `bubble` countdown from the hazard unit and, for each nonzero count, loads a NOP into ID instead of the fetched instruction. On the first cycle of a new countdown it issues a one-cycle PC redirect to the resolved branch/jump target. It also checks that the countdown sequence is legal.

## Interface
Parameters:
- `NOP_WORD`, default 32'h0000_0000: word injected into ID while squashing (`sll $0,$0,0`).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous active-low reset (sampled on `clk` rising edge).
- `bubble`  in  2  countdown from the hazard unit: 3 on a taken branch/jump, then 2, 1, 0.
- `br_target`  in  32  resolved target; valid in the cycle `bubble` first reads 3.
- `if_pc`  in  32  PC of the instruction in IF.
- `if_instr`  in  32  instruction word in IF.
- `stall`  in  1  data-hazard hold request for IF/ID.
- `id_pc`  out  32  IF/ID registered PC.
- `id_instr`  out  32  IF/ID registered instruction.
- `id_valid`  out  1  ID holds a real (non-squashed) instruction.
- `pc_load`  out  1  one-cycle pulse: PC must load `pc_next`.
- `pc_next`  out  32  redirect target, valid while `pc_load`=1.
- `seq_err`  out  1  sticky: illegal `bubble` transition observed.
- `squash_cnt`  out  16  saturating count of squashed slots (only with `SQUASH_STATS_EN`).

## Operation
- FSM with two states:
  - `IDLE`: `bubble`==3 at an edge moves to `DRAIN`.
  - `DRAIN`: `bubble`==0 at an edge returns to `IDLE`.
- Redirect: on the `IDLE`→`DRAIN` edge, register `pc_load`=1 and `pc_next`=`br_target`. On every other edge, `pc_load`=0 and `pc_next` holds its value.
- IF/ID update at each edge, in priority order:
  - `bubble`!=0: `id_instr`=`NOP_WORD`, `id_pc`=`if_pc`, `id_valid`=0. Squash overrides `stall`.
  - `bubble`==0 and `stall`=1: hold all three registers.
  - Otherwise: load `if_instr`/`if_pc`, `id_valid`=1.
- Sequence checker:
  - A `prev_bubble` register tracks the last sampled value.
  - Legal transitions (prev→cur): 0→0, 0→3, 3→2, 2→1, 1→0.
  - Any other transition sets `seq_err`=1 until reset.
  - A 3 sampled in `DRAIN` does not raise a second `pc_load`.
- Width rules: 32-bit PCs pass through unmodified; no arithmetic on targets.

## Timing
- Reset values: `id_pc`=0, `id_instr`=`NOP_WORD`, `id_valid`=0, `pc_load`=0, `pc_next`=0, `seq_err`=0, `squash_cnt`=0, state `IDLE`, `prev_bubble`=0.
- Latency: `bubble`=3 sampled at edge E gives `pc_load`=1 during E..E+1 and NOP in ID from E.
- A 3,2,1 countdown squashes exactly three consecutive slots. `id_valid` returns to 1 at the first edge with `bubble`==0 and `stall`=0.
- `stall` during a countdown is ignored. `stall` in the cycle `bubble` returns to 0 holds the NOP with `id_valid`=0.
- Back-to-back branches: a new 3 arriving after 1→0 (0→3 next cycle) is a legal new redirect.
- Reset mid-`DRAIN`: all outputs return to reset values at that edge, and no `pc_load` is produced. The countdown still in flight is then checked from `prev_bubble`=0, so a nonzero value after reset sets `seq_err`.

## Configuration
- `SQUASH_STATS_EN` defined:
  - `squash_cnt` increments by 1 at every edge where `bubble`!=0.
  - It saturates at 16'hFFFF and clears only on reset.
- `SQUASH_STATS_EN` undefined: the counter is not built and `squash_cnt` is tied to 16'h0000.
- Either way, the other outputs are cycle-identical.

## Test plan
- Reset, then `bubble`=0, `if_instr`=32'h2008_0005, `if_pc`=32'h0040_0000 → next edge: `id_instr`=32'h2008_0005, `id_valid`=1, `pc_load`=0.
- `bubble` 3,2,1,0 with `br_target`=32'h0040_0100 on the 3 cycle:
  - `pc_load` high exactly one cycle with `pc_next`=32'h0040_0100.
  - Three NOP slots with `id_valid`=0, then a normal load.
  - `squash_cnt`=3 with the macro defined.
- `stall`=1 held across a 3,2,1 countdown → NOPs still injected. With `stall`=1 and `bubble`=0 afterwards, `id_instr` stays `NOP_WORD`.
- `bubble` sequence 0,3,2,3 → `seq_err`=1 after the fourth edge, stays 1, and no second `pc_load`. After `rst_n`=0 for one edge, `seq_err`=0.
- `rst_n` low during `bubble`=2 → all outputs at reset values on the next edge. `bubble`=1 on the following edge sets `seq_err` (0→1 illegal).
- Countdowns 0,3,2,1,0,3,2,1,0 → two `pc_load` pulses 4 cycles apart, `seq_err`=0, `squash_cnt`=6.
